bus_slave_port: RTL

Serial-bus responder for the ADS shared bus: receives a serial address frame from the arbitrated master side and commits write frames into a local byte memory, or returns read data serially. One instance sits behind each slave select on the bus; the 2 MSBs of the 14-bit system address are decoded upstream, and this block sees only the 12-bit local address. It is the receiving end of the master port's serial frames and the transmitting end of read data.

---
 rtl/bus_pkg.sv | 28 ++
 rtl/bus_slave_port_if.sv | 29 ++
 rtl/slave_memory.sv | 30 +++
 rtl/bus_slave_port.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared ADS bus definitions: frame widths, slave-select width, slave FSM encoding
// and frame-length constants used by the master port, arbiter and slave port.
package bus_pkg;

    localparam int unsigned BUS_ADDR_WIDTH  = 12;
    localparam int unsigned BUS_DATA_WIDTH  = 8;
    localparam int unsigned SLAVE_SEL_WIDTH = 2;
    localparam int unsigned SYS_ADDR_WIDTH  = SLAVE_SEL_WIDTH + BUS_ADDR_WIDTH;

    // Edges from the first address bit until s_ready is high again.
    localparam int unsigned WRITE_FRAME_CYCLES = BUS_ADDR_WIDTH + BUS_DATA_WIDTH + 1;
    localparam int unsigned READ_FRAME_CYCLES  = BUS_ADDR_WIDTH + BUS_DATA_WIDTH + 1;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StAddr  = 3'd1,
        StWdata = 3'd2,
        StWrite = 3'd3,
        StRdata = 3'd4
    } slave_state_e;

    function automatic int unsigned bit_cnt_width(input int unsigned aw, input int unsigned dw);
        int unsigned m;
        m = (aw > dw) ? aw : dw;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/bus_slave_port_if.sv
// Serial frame signals between the arbitrated master side and one slave port.
interface bus_slave_port_if;

    logic s_valid;
    logic s_rw;
    logic s_serial_in;
    logic s_ready;
    logic s_rvalid;
    logic s_serial_out;

    modport master (
        output s_valid,
        output s_rw,
        output s_serial_in,
        input  s_ready,
        input  s_rvalid,
        input  s_serial_out
    );

    modport slave (
        input  s_valid,
        input  s_rw,
        input  s_serial_in,
        output s_ready,
        output s_rvalid,
        output s_serial_out
    );

endinterface

// File: rtl/slave_memory.sv
// Single-port synchronous byte RAM; registered read, read-during-write returns old data.
module slave_memory #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned MEM_DEPTH  = 4096
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_slave_port.sv
// Serial-bus responder: shifts in address/write-data frames LSB first, commits writes
// to the local RAM and returns read bytes serially with a fixed one-cycle latency.
module bus_slave_port
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = BUS_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = BUS_DATA_WIDTH,
    parameter int unsigned MEM_DEPTH  = 2 ** BUS_ADDR_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    bus_slave_port_if.slave bus
);

    localparam int unsigned CntW  = bit_cnt_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int unsigned DIdxW = $clog2(DATA_WIDTH);

    localparam logic [CntW-1:0] AddrLast = CntW'(ADDR_WIDTH - 1);
    localparam logic [CntW-1:0] DataLast = CntW'(DATA_WIDTH - 1);
    localparam logic [CntW-1:0] DataDone = CntW'(DATA_WIDTH);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    slave_state_e          state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  rw_q, rw_d;
    logic                  rvalid_q, rvalid_d;
    logic                  sout_q, sout_d;

    logic                  mem_we;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            rw_q     <= 1'b0;
            rvalid_q <= 1'b0;
            sout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rw_q     <= rw_d;
            rvalid_q <= rvalid_d;
            sout_q   <= sout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rw_d     = rw_q;
        rvalid_d = 1'b0;
        sout_d   = 1'b0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        mem_addr = addr_q;

        unique case (state_q)
            StIdle: begin
                if (bus.s_valid) begin
                    rw_d      = bus.s_rw;
                    addr_d    = '0;
                    addr_d[0] = bus.s_serial_in;
                    data_d    = '0;
                    cnt_d     = CntOne;
                    state_d   = StAddr;
                end
            end
            StAddr: begin
                if (!bus.s_valid) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    addr_d  = '0;
                    data_d  = '0;
                end else begin
                    addr_d[cnt_q] = bus.s_serial_in;
                    if (cnt_q == AddrLast) begin
                        cnt_d = '0;
                        if (rw_q) begin
                            // Issue the read with the bit arriving on this edge included.
                            mem_re   = 1'b1;
                            mem_addr = addr_d;
                            state_d  = StRdata;
                        end else begin
                            state_d = StWdata;
                        end
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
            end
            StWdata: begin
                if (!bus.s_valid) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    addr_d  = '0;
                    data_d  = '0;
                end else begin
                    data_d[cnt_q[DIdxW-1:0]] = bus.s_serial_in;
                    if (cnt_q == DataLast) begin
                        cnt_d   = '0;
                        state_d = StWrite;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
            end
            StWrite: begin
                mem_we   = 1'b1;
                mem_addr = addr_q;
                cnt_d    = '0;
                state_d  = StIdle;
            end
            StRdata: begin
                // Bits launch on DATA_WIDTH edges; the extra edge drops s_rvalid and returns.
                if (cnt_q == DataDone) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    rvalid_d = 1'b1;
                    sout_d   = mem_rdata[cnt_q[DIdxW-1:0]];
                    cnt_d    = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.s_ready      = (state_q == StIdle);
    assign bus.s_rvalid     = rvalid_q;
    assign bus.s_serial_out = sout_q;

    slave_memory #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk_i  (clk),
        .we_i   (mem_we),
        .re_i   (mem_re),
        .addr_i (mem_addr),
        .wdata_i(data_q),
        .rdata_o(mem_rdata)
    );

endmodule
